// File: rtl/dram_bridge_ctrl_pkg.sv
// Shared types and constants for the farm-core to DRAM AXI4-Lite bridge.
package dram_bridge_ctrl_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] DRAM_BASE_ADDR = 17'h10000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4,
    DONE  = 3'd5
  } Bridge_State;

endpackage

// File: rtl/dram_bridge_ctrl.sv
// Single-outstanding AXI4-Lite master: one read (AR/R) or one write (AW+W/B)
// per farm-core request, answered with a one-cycle C_out_valid pulse.
module dram_bridge_ctrl
  import dram_bridge_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = DRAM_BASE_ADDR,
  parameter int                ID_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   C_addr,
  input  logic [DATA_W-1:0] C_data_w,
  input  logic              C_in_valid,
  input  logic              C_r_wb,
  output logic              C_out_valid,
  output logic [DATA_W-1:0] C_data_r,
  output logic              AR_VALID,
  output logic [ADDR_W-1:0] AR_ADDR,
  input  logic              AR_READY,
  input  logic              R_VALID,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic [1:0]        R_RESP,
  output logic              R_READY,
  output logic              AW_VALID,
  output logic [ADDR_W-1:0] AW_ADDR,
  input  logic              AW_READY,
  output logic              W_VALID,
  output logic [DATA_W-1:0] W_DATA,
  input  logic              W_READY,
  input  logic              B_VALID,
  input  logic [1:0]        B_RESP,
  output logic              B_READY
);

  Bridge_State state;
  logic        aw_done;
  logic        w_done;
  logic        aw_fin;
  logic        w_fin;
  logic        unused_resp;

  function automatic logic [ADDR_W-1:0] rec_addr(input logic [ID_W-1:0] idx);
    return BASE_ADDR + ADDR_W'({idx, 2'b00});
  endfunction

  // Responses are never acted on; every transaction completes.
  assign unused_resp = ^{R_RESP, B_RESP};

  // A channel counts as finished if it handshook earlier or is handshaking now.
  assign aw_fin = aw_done | (AW_VALID & AW_READY);
  assign w_fin  = w_done  | (W_VALID  & W_READY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      C_out_valid <= 1'b0;
      C_data_r    <= '0;
      AR_VALID    <= 1'b0;
      AR_ADDR     <= '0;
      R_READY     <= 1'b0;
      AW_VALID    <= 1'b0;
      AW_ADDR     <= '0;
      W_VALID     <= 1'b0;
      W_DATA      <= '0;
      B_READY     <= 1'b0;
    end else begin
      C_out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (C_in_valid) begin
            if (C_r_wb) begin
              AR_VALID <= 1'b1;
              AR_ADDR  <= rec_addr(C_addr);
              state    <= RD_A;
            end else begin
              AW_VALID <= 1'b1;
              AW_ADDR  <= rec_addr(C_addr);
              W_VALID  <= 1'b1;
              W_DATA   <= C_data_w;
              aw_done  <= 1'b0;
              w_done   <= 1'b0;
              state    <= WR_AW;
            end
          end
        end
        RD_A: begin
          if (AR_READY) begin
            AR_VALID <= 1'b0;
            AR_ADDR  <= '0;
            R_READY  <= 1'b1;
            state    <= RD_D;
          end
        end
        RD_D: begin
          if (R_VALID) begin
            C_data_r    <= R_DATA;
            R_READY     <= 1'b0;
            C_out_valid <= 1'b1;
            state       <= DONE;
          end
        end
        WR_AW: begin
          if (AW_VALID && AW_READY) begin
            AW_VALID <= 1'b0;
            AW_ADDR  <= '0;
            aw_done  <= 1'b1;
          end
          if (W_VALID && W_READY) begin
            W_VALID <= 1'b0;
            W_DATA  <= '0;
            w_done  <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            B_READY <= 1'b1;
            state   <= WR_B;
          end
        end
        WR_B: begin
          if (B_VALID) begin
            B_READY     <= 1'b0;
            C_out_valid <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          C_data_r <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_bridge_ctrl.sv
// Directed bench for dram_bridge_ctrl with a configurable AXI4-Lite slave model.
module tb_dram_bridge_ctrl;
  import dram_bridge_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  C_addr;
  logic [31:0] C_data_w;
  logic        C_in_valid;
  logic        C_r_wb;
  logic        C_out_valid;
  logic [31:0] C_data_r;
  logic        AR_VALID;
  logic [16:0] AR_ADDR;
  logic        AR_READY;
  logic        R_VALID;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        R_READY;
  logic        AW_VALID;
  logic [16:0] AW_ADDR;
  logic        AW_READY;
  logic        W_VALID;
  logic [31:0] W_DATA;
  logic        W_READY;
  logic        B_VALID;
  logic [1:0]  B_RESP;
  logic        B_READY;

  dram_bridge_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .C_addr(C_addr), .C_data_w(C_data_w), .C_in_valid(C_in_valid), .C_r_wb(C_r_wb),
    .C_out_valid(C_out_valid), .C_data_r(C_data_r),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Slave timing: READY stall lengths and response latencies (in cycles).
  int ar_wait = 0, aw_wait = 0, w_wait = 0, r_lat = 1, b_lat = 1;
  logic [31:0] mem [int];

  initial begin
    logic s_ar, s_arv, s_r, s_aw, s_awv, s_w, s_wv, s_b, s_rst;
    logic [16:0] s_ar_addr, s_aw_addr, rd_addr, wr_addr;
    logic [31:0] s_wd, wr_data;
    logic r_pend, b_pend, aw_got, w_got;
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    AR_READY = 1'b1; AW_READY = 1'b1; W_READY = 1'b1;
    R_VALID = 1'b0; R_DATA = '0; R_RESP = 2'b00;
    B_VALID = 1'b0; B_RESP = 2'b00;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    forever begin
      @(negedge clk);
      s_arv = AR_VALID; s_ar = AR_VALID && AR_READY; s_ar_addr = AR_ADDR;
      s_r = R_VALID && R_READY;
      s_awv = AW_VALID; s_aw = AW_VALID && AW_READY; s_aw_addr = AW_ADDR;
      s_wv = W_VALID; s_w = W_VALID && W_READY; s_wd = W_DATA;
      s_b = B_VALID && B_READY;
      s_rst = !rst_n;
      @(posedge clk); #1;
      if (s_rst) begin
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        R_VALID = 1'b0; B_VALID = 1'b0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
        if (s_r) begin R_VALID = 1'b0; r_pend = 0; end
        if (s_ar) begin r_pend = 1; r_cnt = 0; rd_addr = s_ar_addr; end
        if (r_pend && !R_VALID) begin
          r_cnt++;
          if (r_cnt >= r_lat) begin
            R_VALID = 1'b1;
            R_DATA = mem.exists(int'(rd_addr)) ? mem[int'(rd_addr)] : 32'h0;
          end
        end
        if (s_aw) begin aw_got = 1; wr_addr = s_aw_addr; end
        if (s_w) begin w_got = 1; wr_data = s_wd; end
        if (s_b) begin B_VALID = 1'b0; b_pend = 0; end
        if (aw_got && w_got) begin
          mem[int'(wr_addr)] = wr_data;
          aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
        end
        if (b_pend && !B_VALID) begin
          b_cnt++;
          if (b_cnt >= b_lat) B_VALID = 1'b1;
        end
        ar_cnt = (s_arv && !s_ar) ? ar_cnt + 1 : 0;
        aw_cnt = (s_awv && !s_aw) ? aw_cnt + 1 : 0;
        w_cnt  = (s_wv && !s_w) ? w_cnt + 1 : 0;
      end
      AR_READY = (ar_cnt >= ar_wait);
      AW_READY = (aw_cnt >= aw_wait);
      W_READY  = (w_cnt >= w_wait);
    end
  end

  // Drives a one-cycle request; returns just after the edge that sampled it.
  task automatic strobe(input logic rwb, input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    C_in_valid = 1'b1; C_r_wb = rwb; C_addr = a; C_data_w = d;
    @(posedge clk); #1;
    C_in_valid = 1'b0; C_r_wb = 1'b0; C_addr = '0; C_data_w = '0;
  endtask

  task automatic wait_out(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (C_out_valid) begin lat = i; break; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] all_outs;
  assign all_outs = {26'(0), C_out_valid, AR_VALID, R_READY, AW_VALID, W_VALID, B_READY}
                    | C_data_r | 32'(AR_ADDR) | 32'(AW_ADDR) | W_DATA;

  initial begin
    int lat, aw_n, w_n, ar_n, rr_n, outs, bad;
    logic [31:0] got_data;
    rst_n = 1'b0; C_in_valid = 1'b0; C_r_wb = 1'b0; C_addr = '0; C_data_w = '0;
    mem[32'h10014] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs, 32'h0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Read, minimum latency.
    strobe(1'b1, 8'h05, 32'h0);
    @(negedge clk);
    chk("rd_ar_valid", 32'(AR_VALID), 32'd1);
    chk("rd_ar_addr", 32'(AR_ADDR), 32'h10014);
    chk("rd_r_ready_c1", 32'(R_READY), 32'd0);
    @(negedge clk);
    chk("rd_ar_drop", 32'(AR_VALID), 32'd0);
    chk("rd_ar_addr_zero", 32'(AR_ADDR), 32'h0);
    chk("rd_r_ready_c2", 32'(R_READY), 32'd1);
    chk("rd_no_early_out", 32'(C_out_valid), 32'd0);
    @(negedge clk);
    chk("rd_out_c3", 32'(C_out_valid), 32'd1);
    chk("rd_data", C_data_r, 32'hDEADBEEF);
    chk("rd_r_ready_c3", 32'(R_READY), 32'd0);
    @(negedge clk);
    chk("rd_out_c4", 32'(C_out_valid), 32'd0);
    chk("rd_data_clear", C_data_r, 32'h0);
    idle(2);

    // Write to the top record, then read it back.
    strobe(1'b0, 8'hFF, 32'h12345678);
    @(negedge clk);
    chk("wr_aw_valid", 32'(AW_VALID), 32'd1);
    chk("wr_w_valid", 32'(W_VALID), 32'd1);
    chk("wr_aw_addr", 32'(AW_ADDR), 32'h103FC);
    chk("wr_w_data", W_DATA, 32'h12345678);
    chk("wr_b_ready_c1", 32'(B_READY), 32'd0);
    @(negedge clk);
    chk("wr_valids_drop", 32'({AW_VALID, W_VALID}), 32'd0);
    chk("wr_b_ready_c2", 32'(B_READY), 32'd1);
    @(negedge clk);
    chk("wr_out_c3", 32'(C_out_valid), 32'd1);
    chk("wr_data_zero", C_data_r, 32'h0);
    chk("wr_b_ready_c3", 32'(B_READY), 32'd0);
    @(negedge clk);
    chk("wr_out_c4", 32'(C_out_valid), 32'd0);
    idle(2);
    strobe(1'b1, 8'hFF, 32'h0);
    wait_out(10, lat);
    chk("rb_latency", 32'(lat), 32'd3);
    chk("rb_data", C_data_r, 32'h12345678);
    idle(3);

    // Write skew: AW stalled 4 cycles, W accepted at once.
    aw_wait = 4; w_wait = 0;
    idle(2);
    strobe(1'b0, 8'h10, 32'hA5A5_5A5A);
    aw_n = 0; w_n = 0; outs = 0; bad = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (AW_VALID) begin aw_n++; if (AW_ADDR !== 17'h10040) bad++; end
      if (W_VALID) w_n++;
      if (B_READY && (AW_VALID || W_VALID)) bad++;
      if (C_out_valid) outs++;
    end
    chk("skew_aw_cycles", 32'(aw_n), 32'd5);
    chk("skew_w_cycles", 32'(w_n), 32'd1);
    chk("skew_stable", 32'(bad), 32'd0);
    chk("skew_outs", 32'(outs), 32'd1);
    aw_wait = 0;
    idle(2);
    strobe(1'b1, 8'h10, 32'h0);
    wait_out(10, lat);
    chk("skew_readback", C_data_r, 32'hA5A5_5A5A);
    idle(3);

    // Read stall: AR held off 10 cycles, R 7 cycles after the handshake.
    ar_wait = 10; r_lat = 7;
    idle(2);
    strobe(1'b1, 8'h05, 32'h0);
    ar_n = 0; rr_n = 0; outs = 0; bad = 0; got_data = '0; lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (AR_VALID) begin ar_n++; if (AR_ADDR !== 17'h10014) bad++; end
      if (R_READY) begin rr_n++; if (AR_VALID) bad++; end
      if (C_out_valid) begin outs++; got_data = C_data_r; lat = i; end
    end
    chk("stall_ar_cycles", 32'(ar_n), 32'd11);
    chk("stall_r_ready_cycles", 32'(rr_n), 32'd7);
    chk("stall_stable", 32'(bad), 32'd0);
    chk("stall_outs", 32'(outs), 32'd1);
    chk("stall_latency", 32'(lat), 32'd19);
    chk("stall_data", got_data, 32'hDEADBEEF);
    ar_wait = 0; r_lat = 4;
    idle(3);

    // Request strobe while waiting in RD_D is ignored.
    strobe(1'b1, 8'h05, 32'h0);
    ar_n = 0; aw_n = 0; outs = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        C_in_valid = 1'b1; C_r_wb = 1'b0; C_addr = 8'h20; C_data_w = 32'h0BAD_F00D;
      end else begin
        C_in_valid = 1'b0; C_r_wb = 1'b0; C_addr = '0; C_data_w = '0;
      end
      @(negedge clk);
      if (i == 3) chk("ign_in_rd_d", 32'(dut.state), 32'(RD_D));
      if (AR_VALID) ar_n++;
      if (AW_VALID || W_VALID) aw_n++;
      if (C_out_valid) outs++;
      @(posedge clk); #1;
    end
    chk("ign_ar_cycles", 32'(ar_n), 32'd1);
    chk("ign_no_write", 32'(aw_n), 32'd0);
    chk("ign_outs", 32'(outs), 32'd1);
    r_lat = 1;
    idle(2);

    // Reset while waiting for B.
    b_lat = 20;
    idle(2);
    strobe(1'b0, 8'h30, 32'h7777_0000);
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr_b_ready", 32'(B_READY), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", all_outs, 32'h0);
    chk("midrst_state", 32'(dut.state), 32'(IDLE));
    b_lat = 1;
    outs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (C_out_valid) outs++;
    end
    chk("midrst_no_out", 32'(outs), 32'd0);
    idle(1);
    strobe(1'b1, 8'h05, 32'h0);
    wait_out(10, lat);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_data", C_data_r, 32'hDEADBEEF);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dram_bridge_ctrl.md
Name: dram_bridge_ctrl

Overview:
- AXI4-Lite master controller between the farm core's simple C_* request port and the DRAM slave.
- Sequences one single-beat read (AR then R) or one write (AW and W, then B) per request, then returns one C_out_valid pulse to the farm core.
- Holds exactly one outstanding transaction; the farm core never pipelines requests.

Parameters:
- BASE_ADDR, 17'h10000, DRAM byte address of record 0.
- ID_W, 8, width of C_addr (record index).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- C_addr  in  8  record index
- C_data_w  in  32  write data
- C_in_valid  in  1  one-cycle request strobe
- C_r_wb  in  1  1 = read, 0 = write
- C_out_valid  out  1  one-cycle completion strobe
- C_data_r  out  32  read data, valid with C_out_valid
- AR_VALID  out  1  read address valid
- AR_ADDR  out  17  read address
- AR_READY  in  1  read address ready
- R_VALID  in  1  read data valid
- R_DATA  in  32  read data
- R_RESP  in  2  read response (ignored)
- R_READY  out  1  read data ready
- AW_VALID  out  1  write address valid
- AW_ADDR  out  17  write address
- AW_READY  in  1  write address ready
- W_VALID  out  1  write data valid
- W_DATA  out  32  write data
- W_READY  in  1  write data ready
- B_VALID  in  1  write response valid
- B_RESP  in  2  write response (ignored)
- B_READY  out  1  write response ready

Behaviour:
- Reset: clk and rst_n are a single clock, with synchronous active-low reset. Sampled at a clk edge with rst_n=0, every output is 0 and the FSM goes to IDLE. Reset mid-transaction abandons the transaction with no C_out_valid.
- All outputs are registered.
- Address: ADDR = BASE_ADDR + {C_addr, 2'b00}, 17-bit with no overflow. Range is 0x10000–0x103FC.
- Request capture:
  - Latched in IDLE when C_in_valid=1: address, data and r_wb are captured.
  - C_in_valid outside IDLE is ignored; no queueing.
- FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B, DONE.
- IDLE -> RD_A (read): AR_VALID=1 and AR_ADDR valid from the cycle after the strobe.
- RD_A -> RD_D:
  - Transition on the edge where AR_VALID && AR_READY.
  - On that edge AR_VALID drops, AR_ADDR returns to 0 and R_READY rises.
- RD_D -> DONE:
  - Transition on R_VALID && R_READY.
  - C_data_r <= R_DATA and R_READY drops.
- IDLE -> WR_AW (write):
  - AW_VALID=1 and W_VALID=1 together from the cycle after the strobe, with AW_ADDR and W_DATA valid.
  - Each VALID drops independently on its own handshake; an internal done flag is kept per channel.
  - When both channels are done (same edge or different edges), the FSM goes to WR_B with B_READY=1.
- WR_B -> DONE: transition on B_VALID && B_READY; B_READY drops.
- DONE:
  - C_out_valid=1 for exactly one cycle, then IDLE.
  - C_data_r holds the read value during C_out_valid, or 0 for writes. It returns to 0 the next cycle.
- VALID stability: once asserted, AR/AW/W VALID and their address/data hold stable until the handshake. No combinational dependence on READY.
- Minimum latency (READY already high, slave responds next cycle):
  - Read: C_in_valid at cycle 0 -> AR handshake at cycle 1 -> R at cycle 2 -> C_out_valid at cycle 3.
  - Write: C_in_valid at cycle 0 -> AW/W at cycle 1 -> B at cycle 2 -> C_out_valid at cycle 3.
- RESP values are ignored; a transaction always completes.
- No timeout: the block waits indefinitely on a stalled slave.

Decomposition:
- Package (usertype) holds: BASE_ADDR default, the state enum Bridge_State (IDLE, RD_A, RD_D, WR_AW, WR_B, DONE), and the AXI address/data width constants.
- No sub-module: a single FSM plus the capture registers.
- The block is wrapped as the bridge using the bridge_inf modport of the existing interface.

Test Plan:
- Read, C_addr=8'h05, DRAM[0x10014]=32'hDEADBEEF, READY always high -> AR_ADDR=17'h10014, C_out_valid exactly 3 cycles after the strobe, C_data_r=32'hDEADBEEF for one cycle.
- Write, C_addr=8'hFF, C_data_w=32'h12345678 -> AW_ADDR=17'h103FC, W_DATA=32'h12345678, B_READY only after both handshakes, C_out_valid one cycle with C_data_r=0, and a readback returns 32'h12345678.
- Write skew: AW_READY delayed 4 cycles, W_READY immediate -> W_VALID drops after 1 cycle, AW_VALID held 5 cycles with a stable address, exactly one C_out_valid.
- Read stall: AR_READY low 10 cycles, then R_VALID 7 cycles after the AR handshake -> AR_VALID/AR_ADDR stable throughout, R_READY high only in RD_D, a single C_out_valid.
- C_in_valid pulsed while in RD_D -> ignored: no second transaction and only one C_out_valid.
- rst_n=0 for one edge during WR_B -> next cycle all outputs 0 and FSM in IDLE; a fresh read afterwards completes normally.
